// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush controller for a 5-stage in-order pipeline.
// It resolves load-use hazards, taken jumps, multi-cycle MDU ops, WFI
// sleep, and interrupt entry/return.
// Control outputs are combinational in the current state and pipeline
// inputs, because flushes and bubbles must act in the same cycle as
// the event that causes them.
module pipe_hazard_ctrl #(
   parameter int unsigned MDU_LAT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] IF_ID_rs1,
   input  logic [4:0] IF_ID_rs2,
   input  logic       IF_ID_use_rs1,
   input  logic       IF_ID_use_rs2,
   input  logic [4:0] ID_EX_rd,
   input  logic       ID_EX_memread_1bit,
   input  logic       ex_jump_taken,
   input  logic       ex_mdu_start,
   input  logic       ex_wfi,
   input  logic       ex_mret,
   input  logic       irq_pending,
   input  logic       imem_wait,
   input  logic       dmem_wait,
   output logic       stall_CPU,
   output logic       stall_hazard,
   output logic       flush_if_id,
   output logic       flush_id_ex,
   output logic       irq_take,
   output logic       mdu_done,
   output logic       wfi_active,
   output logic       in_handler,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_MDU_BUSY  = 2'd1,
      ST_WFI_SLEEP = 2'd2,
      ST_IRQ_ENTER = 2'd3
   } state_t;

   // Start cycle counts as one EX cycle and the counter==0 cycle as another,
   // so the countdown starts at MDU_LAT-2.
   localparam logic [3:0] C_MDU_LOAD = 4'(MDU_LAT - 2);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;
   logic       r_in_handler;
   logic       w_in_handler_nxt;

   logic       w_mem_stall;
   logic       w_load_use;
   logic       w_irq_req;
   logic       w_stall_hazard;
   logic       w_flush_if_id;
   logic       w_flush_id_ex;
   logic       w_irq_take;
   logic       w_mdu_done;
   logic       w_wfi_active;

   // Hazard detection terms shared by every state.
   always_comb begin
      w_mem_stall = imem_wait | dmem_wait;
      w_load_use  = ID_EX_memread_1bit & (ID_EX_rd != 5'd0) &
                    ((IF_ID_use_rs1 & (IF_ID_rs1 == ID_EX_rd)) |
                     (IF_ID_use_rs2 & (IF_ID_rs2 == ID_EX_rd)));
      // Nested interrupts are blocked while the handler runs.
      w_irq_req   = irq_pending & ~r_in_handler;
   end

   // Next-state and pipeline control decode; a memory stall freezes everything.
   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_in_handler_nxt = r_in_handler;
      w_stall_hazard   = 1'b0;
      w_flush_if_id    = 1'b0;
      w_flush_id_ex    = 1'b0;
      w_irq_take       = 1'b0;
      w_mdu_done       = 1'b0;
      w_wfi_active     = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_mem_stall) begin
               w_state_nxt = r_state;
            end else begin
               // MRET leaves the handler regardless of the event taken below.
               if (ex_mret) begin
                  w_in_handler_nxt = 1'b0;
               end else begin
                  w_in_handler_nxt = r_in_handler;
               end
               if (w_irq_req) begin
                  w_state_nxt = ST_IRQ_ENTER;
               end else if (ex_jump_taken) begin
                  w_flush_if_id = 1'b1;
                  w_flush_id_ex = 1'b1;
               end else if (ex_mdu_start) begin
                  w_cnt_nxt   = C_MDU_LOAD;
                  w_state_nxt = ST_MDU_BUSY;
               end else if (ex_wfi) begin
                  // With an interrupt already pending, WFI retires as a NOP.
                  if (irq_pending) begin
                     w_state_nxt = ST_RUN;
                  end else begin
                     w_state_nxt = ST_WFI_SLEEP;
                  end
               end else if (w_load_use) begin
                  w_stall_hazard = 1'b1;
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end
         end
         ST_MDU_BUSY: begin
            if (w_mem_stall) begin
               w_cnt_nxt = r_cnt;
            end else if (r_cnt == 4'd0) begin
               w_mdu_done  = 1'b1;
               w_state_nxt = ST_RUN;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         ST_WFI_SLEEP: begin
            w_wfi_active = 1'b1;
            // Any pending interrupt wakes the core, even inside a handler.
            if (!w_mem_stall && irq_pending) begin
               w_state_nxt = ST_IRQ_ENTER;
            end else begin
               w_state_nxt = ST_WFI_SLEEP;
            end
         end
         ST_IRQ_ENTER: begin
            if (w_mem_stall) begin
               w_state_nxt = ST_IRQ_ENTER;
            end else begin
               w_irq_take       = 1'b1;
               w_flush_if_id    = 1'b1;
               w_flush_id_ex    = 1'b1;
               w_in_handler_nxt = 1'b1;
               w_state_nxt      = ST_RUN;
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase
   end

   // State, MDU countdown and handler flag; reset abandons any operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_RUN;
         r_cnt        <= 4'd0;
         r_in_handler <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_in_handler <= w_in_handler_nxt;
      end
   end

   // Outputs are forced low while reset is held, except the memory-stall freeze.
   always_comb begin
      stall_CPU    = w_mem_stall | (r_state == ST_MDU_BUSY) | (r_state == ST_WFI_SLEEP);
      stall_hazard = w_stall_hazard & ~rst;
      flush_if_id  = w_flush_if_id  & ~rst;
      flush_id_ex  = w_flush_id_ex  & ~rst;
      irq_take     = w_irq_take     & ~rst;
      mdu_done     = w_mdu_done     & ~rst;
      wfi_active   = w_wfi_active   & ~rst;
      in_handler   = r_in_handler   & ~rst;
      state        = r_state;
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a cycle-level behavioural model
// checks every output on every cycle, plus hand-computed literal checks.
module tb_pipe_hazard_ctrl;
   localparam int MDU_LAT = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
   logic       IF_ID_use_rs1, IF_ID_use_rs2, ID_EX_memread_1bit;
   logic       ex_jump_taken, ex_mdu_start, ex_wfi, ex_mret, irq_pending;
   logic       imem_wait, dmem_wait;
   logic       stall_CPU, stall_hazard, flush_if_id, flush_id_ex;
   logic       irq_take, mdu_done, wfi_active, in_handler;
   logic [1:0] state;

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;

   // Model: mode uses the documented state numbering; left = stall cycles still owed by the MDU
   int m_mode, m_left, n_mode, n_left;
   bit m_hand, n_hand;

   pipe_hazard_ctrl #(.MDU_LAT(MDU_LAT)) dut (
      .clk(clk), .rst(rst),
      .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
      .IF_ID_use_rs1(IF_ID_use_rs1), .IF_ID_use_rs2(IF_ID_use_rs2),
      .ID_EX_rd(ID_EX_rd), .ID_EX_memread_1bit(ID_EX_memread_1bit),
      .ex_jump_taken(ex_jump_taken), .ex_mdu_start(ex_mdu_start),
      .ex_wfi(ex_wfi), .ex_mret(ex_mret), .irq_pending(irq_pending),
      .imem_wait(imem_wait), .dmem_wait(dmem_wait),
      .stall_CPU(stall_CPU), .stall_hazard(stall_hazard),
      .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
      .irq_take(irq_take), .mdu_done(mdu_done),
      .wfi_active(wfi_active), .in_handler(in_handler), .state(state)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_mode = 0; m_left = 0; m_hand = 1'b0;
      n_mode = 0; n_left = 0; n_hand = 1'b0;
   endtask

   // Predict this cycle's outputs from the rules and compare all of them.
   task automatic model_check();
      bit ms, lu, e_sc, e_sh, e_fi, e_fe, e_it, e_md, e_wa, e_ih;
      logic [1:0] e_st;
      logic [9:0] act, expv;
      ms = imem_wait | dmem_wait;
      lu = ID_EX_memread_1bit && ID_EX_rd != 0 &&
           ((IF_ID_use_rs1 && IF_ID_rs1 == ID_EX_rd) || (IF_ID_use_rs2 && IF_ID_rs2 == ID_EX_rd));
      e_sh = 0; e_fi = 0; e_fe = 0; e_it = 0; e_md = 0; e_wa = 0;
      n_mode = m_mode; n_left = m_left; n_hand = m_hand;
      if (rst) begin
         e_sc = ms; e_ih = 0; e_st = 2'd0;
      end else begin
         e_sc = ms || m_mode == 1 || m_mode == 2;
         e_ih = m_hand;
         e_st = 2'(m_mode);
         if (m_mode == 2) e_wa = 1;
         if (!ms) begin
            if (m_mode == 0) begin
               if (ex_mret) n_hand = 0;
               if (irq_pending && !m_hand) n_mode = 3;
               else if (ex_jump_taken) begin e_fi = 1; e_fe = 1; end
               else if (ex_mdu_start) begin n_mode = 1; n_left = MDU_LAT - 1; end
               else if (ex_wfi) begin if (!irq_pending) n_mode = 2; end
               else if (lu) e_sh = 1;
            end else if (m_mode == 1) begin
               if (m_left == 1) begin e_md = 1; n_mode = 0; n_left = 0; end
               else n_left = m_left - 1;
            end else if (m_mode == 2) begin
               if (irq_pending) n_mode = 3;
            end else begin
               e_it = 1; e_fi = 1; e_fe = 1; n_hand = 1; n_mode = 0;
            end
         end
      end
      act  = {stall_CPU, stall_hazard, flush_if_id, flush_id_ex, irq_take,
              mdu_done, wfi_active, in_handler, state};
      expv = {e_sc, e_sh, e_fi, e_fe, e_it, e_md, e_wa, e_ih, e_st};
      n_vec++;
      if (act !== expv) begin
         n_miss++;
         $display("FAIL model cyc=%0d got=%b want=%b (sc sh fi fe it md wa ih st)", cyc, act, expv);
      end
   endtask

   task automatic at_neg();
      @(negedge clk);
      model_check();
   endtask

   task automatic at_pos();
      @(posedge clk);
      if (rst) model_reset();
      else begin m_mode = n_mode; m_left = n_left; m_hand = n_hand; end
      #1;
      cyc++;
   endtask

   task automatic step(int n);
      for (int i = 0; i < n; i++) begin
         at_neg();
         at_pos();
      end
   endtask

   task automatic chk(string nm, logic [3:0] act, logic [3:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_miss++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, expv);
      end
   endtask

   task automatic clear_in();
      IF_ID_rs1 = 5'd0; IF_ID_rs2 = 5'd0; ID_EX_rd = 5'd0;
      IF_ID_use_rs1 = 1'b0; IF_ID_use_rs2 = 1'b0; ID_EX_memread_1bit = 1'b0;
      ex_jump_taken = 1'b0; ex_mdu_start = 1'b0; ex_wfi = 1'b0; ex_mret = 1'b0;
      irq_pending = 1'b0; imem_wait = 1'b0; dmem_wait = 1'b0;
   endtask

   task automatic set_lu(logic [4:0] rd);
      ID_EX_memread_1bit = 1'b1; ID_EX_rd = rd; IF_ID_rs2 = 5'd5; IF_ID_use_rs2 = 1'b1;
   endtask

   // Directed stimulus with literal pins on the key cycles.
   initial begin
      model_reset();
      clear_in();
      rst = 1'b1;
      // Reset: outputs low, stall_CPU follows the memory stall.
      at_neg(); chk("rst_state", 4'(state), 4'd0); chk("rst_stall", 4'(stall_CPU), 4'd0); at_pos();
      imem_wait = 1'b1; ex_jump_taken = 1'b1;
      at_neg(); chk("rst_memstall", 4'(stall_CPU), 4'd1); chk("rst_noflush", 4'(flush_if_id), 4'd0); at_pos();
      clear_in(); rst = 1'b0;
      step(1);

      // Load-use on rs2, then the same with rd=0, then rs1 match but unused.
      set_lu(5'd5);
      at_neg(); chk("lu_stall", 4'(stall_hazard), 4'd1); at_pos();
      set_lu(5'd0); IF_ID_rs2 = 5'd0;
      at_neg(); chk("lu_rd0", 4'(stall_hazard), 4'd0); at_pos();
      clear_in(); ID_EX_memread_1bit = 1'b1; ID_EX_rd = 5'd7; IF_ID_rs1 = 5'd7;
      step(1);
      IF_ID_use_rs1 = 1'b1;
      step(1);

      // Jump beats load-use.
      clear_in(); set_lu(5'd5); ex_jump_taken = 1'b1;
      at_neg(); chk("jmp_fi", 4'(flush_if_id), 4'd1); chk("jmp_fe", 4'(flush_id_ex), 4'd1);
      chk("jmp_sh", 4'(stall_hazard), 4'd0); at_pos();
      // Memory stall suppresses flush and bubble.
      imem_wait = 1'b1;
      at_neg(); chk("ms_fi", 4'(flush_if_id), 4'd0); chk("ms_sc", 4'(stall_CPU), 4'd1); at_pos();
      clear_in();

      // MDU: three busy cycles, done on the third.
      ex_mdu_start = 1'b1;
      at_neg(); chk("mdu_c0_sc", 4'(stall_CPU), 4'd0); at_pos();
      clear_in();
      for (int i = 1; i <= 3; i++) begin
         at_neg();
         chk("mdu_state", 4'(state), 4'd1); chk("mdu_sc", 4'(stall_CPU), 4'd1);
         chk("mdu_done", 4'(mdu_done), (i == 3) ? 4'd1 : 4'd0);
         at_pos();
      end
      at_neg(); chk("mdu_back", 4'(state), 4'd0); at_pos();

      // MDU with a two-cycle dmem stall in the middle.
      ex_mdu_start = 1'b1; step(1); clear_in();
      step(1);
      dmem_wait = 1'b1; step(2); dmem_wait = 1'b0;
      at_neg(); chk("mdux_c4", 4'(mdu_done), 4'd0); at_pos();
      at_neg(); chk("mdux_c5", 4'(mdu_done), 4'd1); at_pos();
      at_neg(); chk("mdux_end", 4'(state), 4'd0); at_pos();

      // WFI sleep, wake at cycle 10, enter at 11.
      ex_wfi = 1'b1; step(1); clear_in();
      at_neg(); chk("wfi_state", 4'(state), 4'd2); chk("wfi_act", 4'(wfi_active), 4'd1);
      chk("wfi_sc", 4'(stall_CPU), 4'd1); at_pos();
      step(8);
      irq_pending = 1'b1;
      at_neg(); chk("wake_c10", 4'(state), 4'd2); at_pos();
      at_neg(); chk("enter_state", 4'(state), 4'd3); chk("enter_take", 4'(irq_take), 4'd1); at_pos();
      at_neg(); chk("hnd_state", 4'(state), 4'd0); chk("hnd_flag", 4'(in_handler), 4'd1); at_pos();

      // Nested IRQ blocked; WFI with pending IRQ is a NOP.
      step(2);
      ex_wfi = 1'b1;
      at_neg(); chk("wfi_nop_take", 4'(irq_take), 4'd0); at_pos();
      ex_wfi = 1'b0;
      at_neg(); chk("wfi_nop_state", 4'(state), 4'd0); at_pos();
      ex_mret = 1'b1; step(1); ex_mret = 1'b0;
      at_neg(); chk("nest_c1", 4'(irq_take), 4'd0); chk("nest_hnd", 4'(in_handler), 4'd0); at_pos();
      at_neg(); chk("nest_c2", 4'(irq_take), 4'd1); at_pos();
      irq_pending = 1'b0;
      step(1);

      // MRET together with a jump.
      ex_mret = 1'b1; ex_jump_taken = 1'b1;
      at_neg(); chk("mret_jmp_fi", 4'(flush_if_id), 4'd1); at_pos();
      clear_in();
      at_neg(); chk("mret_hnd", 4'(in_handler), 4'd0); at_pos();

      // Interrupt from RUN, then async reset mid-MDU while in the handler.
      irq_pending = 1'b1; step(2); irq_pending = 1'b0;
      ex_mdu_start = 1'b1; step(1); clear_in();
      step(1);
      #2 rst = 1'b1;
      #1;
      chk("arst_state", 4'(state), 4'd0); chk("arst_hnd", 4'(in_handler), 4'd0);
      chk("arst_done", 4'(mdu_done), 4'd0);
      model_reset();
      #1 rst = 1'b0;
      step(3);
      ex_mdu_start = 1'b1; step(1); clear_in();
      step(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
